alu_chain_seq: RTL

- Multi-cycle sequencer that runs wide add/subtract operations through a single 4-bit adder slice, one nibble per clock, LSB nibble first.
- Chains the carry between nibbles and accumulates word-level zero and overflow flags.
- Sits between an operation requester and the result consumer, using valid/ready handshakes on both sides.
- Lets the team's 4-bit ALU datapath serve 8/16/32-bit arithmetic without widening the adder.

---
 rtl/alu_chain_pkg.sv | 17 +
 rtl/nibble_add.sv | 25 ++
 rtl/alu_chain_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_chain_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package alu_chain_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_ADC = 2'd2;
    localparam logic [1:0] OP_SBC = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice with carry-out and signed-overflow tap.
module nibble_add
    import alu_chain_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    logic [NIBBLE_W-1:0] low;
    logic [NIBBLE_W:0]   full;

    // low[3] is the carry into the sign bit of the slice
    assign low  = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]}
                + {{(NIBBLE_W-1){1'b0}}, cin};
    assign full = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

    assign sum  = full[NIBBLE_W-1:0];
    assign cout = full[NIBBLE_W];
    assign ovf  = low[NIBBLE_W-1] ^ full[NIBBLE_W];

endmodule

// File: rtl/alu_chain_seq.sv
// Runs W-bit add/sub through one 4-bit slice, LSB nibble first, one per clock.
module alu_chain_seq
    import alu_chain_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic                         req_cin,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  rsp_result,
    output logic                         rsp_carry,
    output logic                         rsp_zero,
    output logic                         rsp_overflow
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    state_t              state;
    state_t              state_nx;
    logic [IDX_W-1:0]    idx;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [W-1:0]        res_q;
    logic                carry_q;
    logic                zero_q;
    logic                ovf_q;

    logic                last;
    logic                accept;
    logic                sub_op;
    logic                cin0;
    logic [NIBBLE_W-1:0] a_n;
    logic [NIBBLE_W-1:0] b_n;
    logic [NIBBLE_W-1:0] sum;
    logic                cout;
    logic                ovf;

    assign last   = idx == IDX_W'(NIBBLES - 1);
    assign accept = (state == IDLE) && req_valid;
    assign a_n    = a_q[{idx, 2'b00} +: NIBBLE_W];
    assign b_n    = b_q[{idx, 2'b00} +: NIBBLE_W];

    nibble_add u_slice (
        .a    (a_n),
        .b    (b_n),
        .cin  (carry_q),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always_comb begin
        sub_op = 1'b0;
        cin0   = req_cin;
        unique case (req_op)
            OP_ADD: cin0 = 1'b0;
            OP_SUB: begin
                sub_op = 1'b1;
                cin0   = 1'b1;
            end
            OP_ADC: cin0 = req_cin;
            OP_SBC: sub_op = 1'b1;
            default: cin0 = req_cin;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_valid) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            a_q     <= req_a;
            // subtraction is A + ~B + carry
            b_q     <= sub_op ? ~req_b : req_b;
            carry_q <= cin0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else if (state == RUN) begin
            res_q[{idx, 2'b00} +: NIBBLE_W] <= sum;
            carry_q <= cout;
            zero_q  <= zero_q & (sum == '0);
            if (last) begin
                ovf_q <= ovf;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign req_ready    = (state == IDLE) && !rst;
    assign rsp_valid    = state == DONE;
    assign rsp_result   = res_q;
    assign rsp_carry    = carry_q;
    assign rsp_zero     = zero_q;
    assign rsp_overflow = ovf_q;

endmodule
